// File: rtl/tlut_tile_sched.sv
// tlut_tile_sched: accumulates N adder-tree product tiles per job, lane by lane.
// Latency: out_valid is high in the second cycle after the final tile acceptance (RUN -> DRAIN -> OUT).
// Backpressure: in_ready is high only in RUN; in OUT the result is held until out_ready is seen high.
//
// Ports:
//   clk, rst_n        - clock (rising edge) and asynchronous active-low reset
//   start             - job start request, sampled only in IDLE
//   cfg_num_tiles     - tiles per job (N), latched when start is accepted; 0 gives an empty job
//   busy              - high in every state except IDLE
//   in_valid/in_ready - tile handshake on the adder-tree prod bus
//   tree_mult         - registered adder-tree output, valid one cycle after each acceptance
//   out_valid/out_ready/out_data - result handshake, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   ovf               - sticky lane-wrap flag for the current job
//   done              - single-cycle pulse at the end of every job (including empty jobs)

module tlut_tile_sched #(
  parameter int DIM_A     = 9,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CNT_W-1:0]           cfg_num_tiles,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIM_A*ACC_WIDTH-1:0] tree_mult,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIM_A*ACC_WIDTH-1:0] out_data,
  output logic                       ovf,
  output logic                       done
);

  localparam int W = DIM_A * ACC_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               accept;
  logic               job_start;
  logic               empty_job;
  logic               last_tile;
  logic [W-1:0]       acc_sum;
  logic [DIM_A-1:0]   lane_carry;

  // ------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------
  assign accept    = in_valid && in_ready;
  assign job_start = (state_q == S_IDLE) && start && (cfg_num_tiles != '0);
  assign empty_job = (state_q == S_IDLE) && start && (cfg_num_tiles == '0);
  // n_q is never 0 while in RUN, so the acceptance that makes cnt reach n_q is the last one.
  assign last_tile = (cnt_q + CNT_W'(1)) == n_q;

  // ------------------------------------------------------------------
  // Per-lane unsigned adders; the extra bit is the lane carry-out
  // ------------------------------------------------------------------
  for (genvar g = 0; g < DIM_A; g++) begin : g_lane
    logic [ACC_WIDTH:0] lane_add;
    assign lane_add = {1'b0, acc_q[g*ACC_WIDTH +: ACC_WIDTH]}
                    + {1'b0, tree_mult[g*ACC_WIDTH +: ACC_WIDTH]};
    assign acc_sum[g*ACC_WIDTH +: ACC_WIDTH] = lane_add[ACC_WIDTH-1:0];
    assign lane_carry[g] = lane_add[ACC_WIDTH];
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (job_start)            state_d = S_RUN;
      S_RUN:   if (accept && last_tile)  state_d = S_DRAIN;
      // DRAIN exists only to absorb the tree's one-cycle latency for the last tile.
      S_DRAIN:                           state_d = S_OUT;
      S_OUT:   if (out_ready)            state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      S_IDLE:  busy      = 1'b0;
      S_RUN:   in_ready  = 1'b1;
      S_DRAIN: ;
      S_OUT:   out_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath next state
  // ------------------------------------------------------------------
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    n_d    = n_q;
    ovf_d  = ovf_q;
    // tree_mult carries the accepted tile's products exactly one cycle later.
    pend_d = accept;
    // done pulses in the cycle after the job ends: either an empty start or the OUT handshake.
    done_d = empty_job || ((state_q == S_OUT) && out_ready);

    if (job_start) begin
      acc_d  = '0;
      cnt_d  = '0;
      n_d    = cfg_num_tiles;
      ovf_d  = 1'b0;
      pend_d = 1'b0;
    end else begin
      if (pend_q) begin
        acc_d = acc_sum;
        ovf_d = ovf_q || (|lane_carry);
      end
      if (accept) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      n_q    <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // The accumulator only changes on pend cycles, so it is already stable throughout OUT.
  assign out_data = acc_q;
  assign ovf      = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tlut_tile_sched.sv
module tb_tlut_tile_sched;

  localparam int DIM_A     = 9;
  localparam int ACC_WIDTH = 32;
  localparam int CNT_W     = 8;
  localparam int W         = DIM_A * ACC_WIDTH;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] cfg_num_tiles;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     tree_mult;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             ovf;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  tlut_tile_sched #(
    .DIM_A    (DIM_A),
    .ACC_WIDTH(ACC_WIDTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_num_tiles(cfg_num_tiles),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tree_mult    (tree_mult),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ovf          (ovf),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i = base + i*inc.
  function automatic logic [W-1:0] mk(input logic [31:0] base, input logic [31:0] inc);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIM_A; i++) begin
      r[i*ACC_WIDTH +: ACC_WIDTH] = base + inc * 32'(i);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [W-1:0] v;

    rst_n = 1'b0;
    start = 1'b0;
    cfg_num_tiles = '0;
    in_valid = 1'b0;
    tree_mult = '0;
    out_ready = 1'b1;
    #3;
    // Reset state
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    chk("rst_out_data", out_data, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- Job A: N=3, continuous tiles 1,2,3 -> every lane 6 ----
    start = 1'b1; cfg_num_tiles = 8'd3;
    tick();
    start = 1'b0;
    chk("a_busy", W'(busy), W'(1));
    chk("a_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    tick();                       // accept 1
    tree_mult = mk(1, 0);
    tick();                       // accept 2, acc += 1
    tree_mult = mk(2, 0);
    tick();                       // accept 3 -> DRAIN, acc += 2
    in_valid = 1'b0;
    tree_mult = mk(3, 0);
    chk("a_drain_in_ready", W'(in_ready), W'(0));
    chk("a_drain_out_valid", W'(out_valid), W'(0));
    tick();                       // final accumulate -> OUT
    chk("a_out_valid", W'(out_valid), W'(1));
    chk("a_out_data", out_data, mk(6, 0));
    chk("a_out_done", W'(done), W'(0));
    tick();                       // handshake -> IDLE
    chk("a_done", W'(done), W'(1));
    chk("a_post_out_valid", W'(out_valid), W'(0));
    chk("a_post_busy", W'(busy), W'(0));
    tick();
    chk("a_done_pulse_end", W'(done), W'(0));

    // ---- Job B: N=4 with 2-cycle gaps; then hold out_ready low ----
    out_ready = 1'b0;
    start = 1'b1; cfg_num_tiles = 8'd4;
    tick();
    start = 1'b0;
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1;
      tick();                     // acceptance edge
      in_valid = 1'b0;
      tree_mult = mk(32'(t + 1), 32'(t + 1));
      if (t < 3) begin
        chk("b_gap1_in_ready", W'(in_ready), W'(1));
        tick();                   // accumulate this tile
        tree_mult = mk(32'hDEAD0000, 32'h11); // junk must not be added
        chk("b_gap2_in_ready", W'(in_ready), W'(1));
        tick();
      end
    end
    chk("b_drain_in_ready", W'(in_ready), W'(0));
    tick();
    tree_mult = mk(32'hBAD00000, 32'h3);
    chk("b_out_valid", W'(out_valid), W'(1));
    chk("b_out_data", out_data, mk(10, 10));
    start = 1'b1; cfg_num_tiles = 8'd7;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("b_hold_out_valid", W'(out_valid), W'(1));
      chk("b_hold_out_data", out_data, mk(10, 10));
      chk("b_hold_done", W'(done), W'(0));
      chk("b_hold_busy", W'(busy), W'(1));
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("b_done", W'(done), W'(1));
    chk("b_post_out_valid", W'(out_valid), W'(0));
    chk("b_post_busy", W'(busy), W'(0));

    // ---- Job C: N=2 lane0 wraps -> lane0 = 1, ovf ----
    start = 1'b1; cfg_num_tiles = 8'd2;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();                       // accept 1
    v = '0; v[31:0] = 32'hFFFF_FFFF;
    tree_mult = v;
    tick();                       // accept 2 -> DRAIN, acc lane0 = FFFFFFFF
    in_valid = 1'b0;
    v = '0; v[31:0] = 32'h2;
    tree_mult = v;
    chk("c_no_ovf_yet", W'(ovf), W'(0));
    tick();                       // wrap -> OUT
    v = '0; v[31:0] = 32'h1;
    chk("c_out_data", out_data, v);
    chk("c_ovf", W'(ovf), W'(1));
    tick();
    chk("c_done", W'(done), W'(1));
    chk("c_ovf_sticky_idle", W'(ovf), W'(1));

    // ---- Job D: N=1, no wrap -> ovf cleared ----
    start = 1'b1; cfg_num_tiles = 8'd1;
    tick();
    start = 1'b0;
    chk("d_ovf_cleared", W'(ovf), W'(0));
    in_valid = 1'b1;
    tick();                       // accept -> DRAIN
    in_valid = 1'b0;
    tree_mult = mk(5, 3);
    tick();
    chk("d_out_data", out_data, mk(5, 3));
    chk("d_ovf", W'(ovf), W'(0));
    tick();
    chk("d_done", W'(done), W'(1));

    // ---- Empty job: cfg_num_tiles = 0 ----
    tick();
    start = 1'b1; cfg_num_tiles = 8'd0;
    tick();
    start = 1'b0;
    chk("e_done", W'(done), W'(1));
    chk("e_busy", W'(busy), W'(0));
    chk("e_out_valid", W'(out_valid), W'(0));
    tick();
    chk("e_done_end", W'(done), W'(0));
    chk("e_out_valid2", W'(out_valid), W'(0));

    // ---- Reset mid-RUN ----
    start = 1'b1; cfg_num_tiles = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();                       // accept 1
    tree_mult = mk(4, 0);
    tick();                       // accept 2, acc = 4
    tree_mult = mk(5, 0);
    chk("r_pre_busy", W'(busy), W'(1));
    chk("r_pre_acc", out_data, mk(4, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_busy", W'(busy), W'(0));
    chk("r_in_ready", W'(in_ready), W'(0));
    chk("r_out_valid", W'(out_valid), W'(0));
    chk("r_done", W'(done), W'(0));
    chk("r_ovf", W'(ovf), W'(0));
    chk("r_out_data", out_data, '0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("r_after_busy", W'(busy), W'(0));
    chk("r_after_in_ready", W'(in_ready), W'(0));
    chk("r_after_out_valid", W'(out_valid), W'(0));
    in_valid = 1'b0;
    start = 1'b1; cfg_num_tiles = 8'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tree_mult = mk(7, 0);
    tick();
    chk("r_new_out_valid", W'(out_valid), W'(1));
    chk("r_new_out_data", out_data, mk(7, 0));
    tick();
    chk("r_new_done", W'(done), W'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
